// File: rtl/switch_event_encoder.sv
// Switch front end: synchronises and debounces four raw switches, then turns
// the clean levels into single-cycle release events, a switch-1 + switch-4
// hold game-reset request, and an error pulse for ambiguous multi-presses.
module switch_event_encoder #(
    parameter int DEBOUNCE_LIMIT  = 250000,
    parameter int RESET_HOLD_CLKS = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_switch,
    output logic [3:0] o_switch_level,
    output logic       o_event_dv,
    output logic [1:0] o_event_id,
    output logic       o_game_reset,
    output logic       o_multi_err
);

    localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
    localparam int HOLD_W = $clog2(RESET_HOLD_CLKS);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    // The hold counter is cleared on COMBO entry; the pulse fires on the
    // cycle it steps onto RESET_HOLD_CLKS-1, i.e. while it still holds -2.
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(RESET_HOLD_CLKS - 2);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    localparam logic [3:0] COMBO_MASK = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        COMBO,
        DRAIN,
        LOCKOUT
    } state_t;

    logic [3:0]        sync_meta;
    logic [3:0]        sync;
    logic [3:0]        level;
    logic [DB_W-1:0]   db_cnt [4];

    state_t            state;
    state_t            next_state;
    logic [1:0]        id_q;
    logic [1:0]        next_id;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic              event_d;
    logic              game_reset_d;
    logic              multi_err_d;
    logic [3:0]        latched_mask;

    // Index of the highest set bit; only ever applied to one-hot values.
    function automatic logic [1:0] bit_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Two-flop synchroniser per switch bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            // NOTE: non-blocking keeps the two stages as separate flops;
            // blocking here would collapse the chain into a single register.
            sync_meta <= i_switch;
            sync      <= sync_meta;
        end
    end

    // Per-bit debounce: the level only follows sync after DEBOUNCE_LIMIT
    // consecutive mismatching samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level <= '0;
            // NOTE: these counters are control state, not storage, so every
            // entry is reset; a true RAM array would be left unreset.
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    assign o_switch_level = level;
    assign latched_mask   = 4'b0001 << id_q;

    // Next-state and pulse decode from the debounced level.
    always_comb begin
        // NOTE: every target gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        next_state   = state;
        next_id      = id_q;
        next_hold    = hold_cnt;
        event_d      = 1'b0;
        game_reset_d = 1'b0;
        multi_err_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (level != 4'b0000) begin
                    if ($onehot(level)) begin
                        next_state = PRESSED;
                        next_id    = bit_index(level);
                    end else if (level == COMBO_MASK) begin
                        next_state = COMBO;
                        next_hold  = '0;
                    end else begin
                        multi_err_d = 1'b1;
                        next_state  = LOCKOUT;
                    end
                end
            end
            PRESSED: begin
                if (level == 4'b0000) begin
                    event_d    = 1'b1;
                    next_state = IDLE;
                end else if (level == latched_mask) begin
                    next_state = PRESSED;
                end else if (level == COMBO_MASK &&
                             (level & latched_mask) != 4'b0000) begin
                    next_state = COMBO;
                    next_hold  = '0;
                end else begin
                    // Covers an extra bit rising, including one rising in the
                    // same cycle the latched switch is released.
                    multi_err_d = 1'b1;
                    next_state  = LOCKOUT;
                end
            end
            COMBO: begin
                if (level == COMBO_MASK) begin
                    next_hold = hold_cnt + HOLD_ONE;
                    if (hold_cnt == HOLD_FIRE) begin
                        game_reset_d = 1'b1;
                        next_state   = DRAIN;
                    end
                end else begin
                    next_state = LOCKOUT;
                end
            end
            DRAIN, LOCKOUT: begin
                if (level == 4'b0000) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, latched ID, hold counter and registered output pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            id_q         <= '0;
            hold_cnt     <= '0;
            o_event_dv   <= 1'b0;
            o_event_id   <= '0;
            o_game_reset <= 1'b0;
            o_multi_err  <= 1'b0;
        end else begin
            state        <= next_state;
            id_q         <= next_id;
            hold_cnt     <= next_hold;
            o_event_dv   <= event_d;
            o_game_reset <= game_reset_d;
            o_multi_err  <= multi_err_d;
            if (event_d) o_event_id <= id_q;
        end
    end

endmodule

// File: tb/tb_switch_event_encoder.sv
// Bench for switch_event_encoder: directed scenarios with literal expectations
// plus randomized switch activity compared every cycle against a behavioural
// model built on sample histories and press "sessions".
module tb_switch_event_encoder;

    localparam int LIMIT = 4;
    localparam int HOLD  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'hF;
    logic [3:0] o_switch_level;
    logic       o_event_dv;
    logic [1:0] o_event_id;
    logic       o_game_reset;
    logic       o_multi_err;

    switch_event_encoder #(
        .DEBOUNCE_LIMIT (LIMIT),
        .RESET_HOLD_CLKS(HOLD)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_switch      (sw),
        .o_switch_level(o_switch_level),
        .o_event_dv    (o_event_dv),
        .o_event_id    (o_event_id),
        .o_game_reset  (o_game_reset),
        .o_multi_err   (o_multi_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Edge counter used by the directed scenarios.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    logic [3:0] m_s1 = '0, m_s2 = '0, m_level = '0;
    logic [3:0] m_hist [LIMIT];
    bit         open = 0, single = 0, poisoned = 0;
    int         first_id = 0, combo_start = 0, m_now = 0;
    logic       exp_dv = 0, exp_rst = 0, exp_err = 0;
    logic [1:0] exp_id = '0;

    initial for (int k = 0; k < LIMIT; k++) m_hist[k] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0;
            for (int k = 0; k < LIMIT; k++) m_hist[k] = '0;
            open = 0; single = 0; poisoned = 0;
            exp_dv = 0; exp_rst = 0; exp_err = 0; exp_id = '0;
        end else begin
            logic [3:0] lv, new_level, mask;
            m_now++;
            lv = m_level;
            exp_dv = 0; exp_rst = 0; exp_err = 0;
            mask = 4'b0001 << first_id;
            // Session interpretation of the pre-edge debounced level.
            if (!open) begin
                if (lv != 0) begin
                    open = 1; single = 0; poisoned = 0;
                    if ($countones(lv) == 1) begin
                        single = 1;
                        for (int b = 0; b < 4; b++) if (lv[b]) first_id = b;
                    end else if (lv == 4'b1001) begin
                        combo_start = m_now;
                    end else begin
                        exp_err = 1; poisoned = 1;
                    end
                end
            end else if (poisoned) begin
                if (lv == 0) open = 0;
            end else if (single) begin
                if (lv == 0) begin
                    exp_dv = 1; exp_id = 2'(first_id); open = 0;
                end else if (lv == mask) begin
                    // still the lone press
                end else if (lv == 4'b1001 && lv[first_id]) begin
                    single = 0; combo_start = m_now;
                end else begin
                    exp_err = 1; poisoned = 1;
                end
            end else begin
                if (lv != 4'b1001) poisoned = 1;
                else if (m_now - combo_start == HOLD - 1) begin
                    exp_rst = 1; poisoned = 1;
                end
            end
            // Debounce: flip a bit once the last LIMIT samples all disagree.
            for (int k = LIMIT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s2;
            new_level = m_level;
            for (int b = 0; b < 4; b++) begin
                bit all_diff;
                all_diff = 1;
                for (int k = 0; k < LIMIT; k++) if (m_hist[k][b] == m_level[b]) all_diff = 0;
                if (all_diff) new_level[b] = ~m_level[b];
            end
            m_level = new_level;
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk)
        check("outputs_vs_model",
              {o_switch_level, o_event_dv, o_event_id, o_game_reset, o_multi_err},
              {m_level, exp_dv, exp_id, exp_rst, exp_err});

    // Pulse bookkeeping for the directed scenarios.
    int         n_dv = 0, n_rst = 0, n_err = 0, rst_cyc = -1;
    logic [1:0] last_id = '0;
    logic [3:0] any_level = '0;
    always @(negedge clk) begin
        if (o_event_dv) begin n_dv++; last_id = o_event_id; end
        if (o_game_reset) begin n_rst++; rst_cyc = cyc; end
        if (o_multi_err) n_err++;
        any_level |= o_switch_level;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_level(input logic [3:0] want, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (o_switch_level === want) begin
                at = cyc;
                return;
            end
        end
        check("wait_level_timeout", 32'(o_switch_level), 32'(want));
    endtask

    task automatic press_release(input logic [3:0] v);
        int t;
        sw = v;
        ticks(10);
        sw = 4'b0000;
        wait_level(4'b0000, 20, t);
        ticks(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, c, d0, r0, e0, start;
        logic [3:0] pick;

        // 1. Reset with all switches held.
        ticks(3);
        check("reset_outputs",
              {o_switch_level, o_event_dv, o_event_id, o_game_reset, o_multi_err}, 9'h000);
        c = cyc; d0 = n_dv; e0 = n_err;
        rst_n = 1'b1;
        wait_level(4'hF, 20, t);
        // Held input is first sampled at edge c+1; level follows LIMIT+1 later.
        check("reset_release_latency", t, c + 1 + LIMIT + 1);
        ticks(3);
        check("reset_multi_err", n_err - e0, 1);
        sw = 4'b0000;
        wait_level(4'b0000, 20, t);
        ticks(3);
        check("lockout_release_no_event", n_dv - d0, 0);

        // 2. Single press of switch 3 (bit 2).
        d0 = n_dv; r0 = n_rst; e0 = n_err;
        sw = 4'b0100;
        c = cyc;
        wait_level(4'b0100, 20, t);
        check("single_rise_latency", t, c + 1 + LIMIT + 1);
        while (cyc < c + 10) tick();
        sw = 4'b0000;
        wait_level(4'b0000, 20, t);
        ticks(3);
        check("single_event_count", n_dv - d0, 1);
        check("single_event_id", last_id, 2);
        check("single_no_other_pulses", (n_err - e0) + (n_rst - r0), 0);

        // 3. Three-clock glitch on bit 0.
        any_level = '0;
        d0 = n_dv; r0 = n_rst; e0 = n_err;
        sw = 4'b0001;
        ticks(3);
        sw = 4'b0000;
        ticks(15);
        check("glitch_level", any_level, 0);
        check("glitch_pulses", (n_dv - d0) + (n_err - e0) + (n_rst - r0), 0);

        // 4. Full combo hold.
        d0 = n_dv; r0 = n_rst; e0 = n_err;
        sw = 4'b1001;
        start = cyc;
        wait_level(4'b1001, 20, t);
        for (int k = 0; k < 20 && n_rst == r0; k++) tick();
        check("combo_reset_delay", rst_cyc - t, HOLD);
        while (cyc < start + 20) tick();
        sw = 4'b0000;
        wait_level(4'b0000, 20, c);
        ticks(3);
        check("combo_reset_count", n_rst - r0, 1);
        check("combo_no_event", n_dv - d0, 0);
        check("combo_no_err", n_err - e0, 0);

        // 5. Combo broken after four debounced clocks, bit 0 stays held.
        d0 = n_dv; r0 = n_rst; e0 = n_err;
        sw = 4'b1001;
        ticks(4);
        sw = 4'b0001;
        wait_level(4'b0001, 20, t);
        ticks(12);
        check("broken_no_reset", n_rst - r0, 0);
        check("broken_no_pulses", (n_dv - d0) + (n_err - e0), 0);
        sw = 4'b0000;
        wait_level(4'b0000, 20, t);
        ticks(3);
        check("broken_release_no_event", n_dv - d0, 0);
        press_release(4'b0001);
        check("broken_fresh_event", n_dv - d0, 1);
        check("broken_fresh_id", last_id, 0);

        // 6. Illegal pair, then a clean press of switch 4.
        d0 = n_dv; e0 = n_err;
        sw = 4'b0010;
        wait_level(4'b0010, 20, t);
        sw = 4'b0110;
        wait_level(4'b0110, 20, t);
        ticks(3);
        check("pair_multi_err", n_err - e0, 1);
        sw = 4'b0000;
        wait_level(4'b0000, 20, t);
        ticks(3);
        check("pair_no_event", n_dv - d0, 0);
        press_release(4'b1000);
        check("pair_followup_event", n_dv - d0, 1);
        check("pair_followup_id", last_id, 3);

        // Randomized activity, checked cycle by cycle against the model.
        for (int seg = 0; seg < 250; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 9: pick = 4'b0000;
                3, 4, 5:    pick = 4'b0001 << $urandom_range(0, 3);
                6:          pick = 4'b1001;
                7:          pick = 4'($urandom_range(0, 15));
                default:    pick = sw ^ (4'b0001 << $urandom_range(0, 3));
            endcase
            sw = pick;
            ticks($urandom_range(1, 20));
            if (seg == 120) begin
                rst_n = 1'b0;
                ticks(2);
                rst_n = 1'b1;
            end
        end
        sw = 4'b0000;
        ticks(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
